// File: rtl/div16_seq_pkg.sv
// div16_seq_pkg: shared constants for the sequential 16-bit divider.
//   DIV_WIDTH        operand/result width, also the number of RUN iterations
//   DIV_CNT_W        iteration counter width, wide enough to hold DIV_WIDTH
//   ST_IDLE/RUN/DONE FSM state encodings, also exported on dbg_state
package div16_seq_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div16_seq_sub17_borrow.sv
// sub17_borrow: W-bit ripple subtractor, diff = a - b, built from FullAdder cells.
// The subtraction is done as a + ~b + 1, so borrow is the inverted carry-out.
//   a      : minuend
//   b      : subtrahend
//   diff   : a - b modulo 2^W
//   borrow : 1 when a < b (unsigned)
// FullAdder: one-bit full adder cell (sum, carry-out).
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module sub17_borrow #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);
    logic [W:0]   carry;
    logic [W-1:0] b_n;

    assign b_n      = ~b;
    assign carry[0] = 1'b1;   // the +1 of the two's complement negation

    for (genvar i = 0; i < W; i++) begin : g_bit
        FullAdder u_fa (
            .a   (a[i]),
            .b   (b_n[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    assign borrow = ~carry[W];
endmodule

// File: rtl/div16_seq.sv
// div16_seq: unsigned restoring divider, one quotient bit per clock.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   start          : request, only looked at in IDLE
//   dividend       : numerator, captured on the accepted start
//   divisor        : denominator, captured on the accepted start
//   busy           : high in RUN and DONE
//   done           : one-cycle pulse in DONE; results valid from then on
//   quotient       : result, held until the next completion
//   remainder      : result, held until the next completion
//   div_by_zero    : set with done when divisor was zero
//   dbg_state      : current FSM state (ST_IDLE / ST_RUN / ST_DONE)
//
// Handshake: a request is taken when start=1 at a rising edge while the
// FSM is in IDLE; start in any other state is dropped. busy rises the cycle
// after acceptance and falls after the single done cycle. A divide-by-zero
// goes straight to DONE; a normal divide spends WIDTH cycles in RUN.
module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(WIDTH - 1);

    logic [1:0]           state_q,     state_d;
    logic [DIV_CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0]     dvd_sr_q,    dvd_sr_d;   // dividend, consumed MSB first
    logic [WIDTH-1:0]     dvs_q,       dvs_d;
    // The stored partial remainder is always below the divisor, so its
    // (WIDTH+1)-th bit is constantly zero and is not kept as a flop.
    logic [WIDTH-1:0]     rem_q,       rem_d;
    logic [WIDTH-2:0]     quo_sr_q,    quo_sr_d;   // quotient bits so far
    logic [WIDTH-1:0]     quotient_q,  quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic                 dbz_q,       dbz_d;

    logic [WIDTH:0]   r_shift;   // R' = {R, next dividend bit}
    logic [WIDTH:0]   t_diff;    // T  = R' - divisor
    logic             t_borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign r_shift = {rem_q, dvd_sr_q[WIDTH-1]};

    sub17_borrow #(
        .W(WIDTH + 1)
    ) u_sub (
        .a     (r_shift),
        .b     ({1'b0, dvs_q}),
        .diff  (t_diff),
        .borrow(t_borrow)
    );

    // R' < 2*divisor, so a borrow shows up exactly as T's sign bit; the
    // restore mux keys off T's MSB and the quotient bit off the borrow.
    assign r_next = t_diff[WIDTH] ? r_shift[WIDTH-1:0] : t_diff[WIDTH-1:0];
    assign q_next = {quo_sr_q, ~t_borrow};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_sr_d    = dvd_sr_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_sr_d    = quo_sr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        dvd_sr_d = dividend;
                        dvs_d    = divisor;
                        rem_d    = '0;
                        quo_sr_d = '0;
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                dvd_sr_d = {dvd_sr_q[WIDTH-2:0], 1'b0};
                rem_d    = r_next;
                quo_sr_d = q_next[WIDTH-2:0];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    // Results land in the output registers as DONE is entered,
                    // leaving the previous results untouched during RUN.
                    quotient_d  = q_next;
                    remainder_d = r_next;
                    dbz_d       = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_sr_q    <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_sr_q    <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_sr_q    <= dvd_sr_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_sr_q    <= quo_sr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_div16_seq.sv
module tb_div16_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] last_q = '0;
    logic [15:0] last_r = '0;
    logic        last_z = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    div16_seq dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one request, counts rising edges from the accepting edge until
    // done is seen, then checks latency, results and the one-cycle done pulse.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input int elat);
        int lat;
        @(negedge clock);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        lat = 1;
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        @(negedge clock);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (!done) begin
            chk("quotient_held_in_run", {16'd0, quotient}, {16'd0, last_q});
            chk("remainder_held_in_run", {16'd0, remainder}, {16'd0, last_r});
        end
        while (!done && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        chk("done_latency", lat, elat);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {16'd0, remainder}, {16'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clock);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        last_q = eq;
        last_r = er;
        last_z = ez;
    endtask

    initial begin : main
        int done_cnt;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,    16'd2,      1'b0, 17};
        vecs[1]  = '{16'hFFFF,  16'h8001,   16'd1,     16'h7FFE,   1'b0, 17};
        vecs[2]  = '{16'h8000,  16'hFFFF,   16'd0,     16'h8000,   1'b0, 17};
        vecs[3]  = '{16'd5,     16'd0,      16'hFFFF,  16'd5,      1'b1, 1};
        vecs[4]  = '{16'd9,     16'd3,      16'd3,     16'd0,      1'b0, 17};
        vecs[5]  = '{16'd0,     16'd5,      16'd0,     16'd0,      1'b0, 17};
        vecs[6]  = '{16'h1234,  16'h0010,   16'h0123,  16'h0004,   1'b0, 17};
        vecs[7]  = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,      1'b0, 17};
        vecs[8]  = '{16'd7,     16'd9,      16'd0,     16'd7,      1'b0, 17};
        vecs[9]  = '{16'd1000,  16'd3,      16'd333,   16'd1,      1'b0, 17};
        vecs[10] = '{16'd0,     16'd0,      16'hFFFF,  16'd0,      1'b1, 1};
        vecs[11] = '{16'd50000, 16'd251,    16'd199,   16'd51,     1'b0, 17};

        // Clock/reset block: hold reset, check the cleared outputs.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat);
        end

        // start pulses at cycle 3 (RUN) and cycle 17 (done) must be dropped.
        @(negedge clock);
        start    = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 16'd1;
        @(posedge clock);
        #1 start = 1'b0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clock);
            if (done) begin
                done_cnt++;
                chk("ignore_done_cycle", cyc, 17);
            end
            if (cyc == 3 || cyc == 17) begin
                start    = 1'b1;
                dividend = 16'd10;
                divisor  = 16'd2;
            end else begin
                start = 1'b0;
            end
        end
        chk("ignore_done_count", done_cnt, 1);
        chk("ignore_quotient", {16'd0, quotient}, 32'h0000FFFF);
        chk("ignore_remainder", {16'd0, remainder}, 32'd0);
        chk("ignore_idle_after", {31'd0, busy}, 32'd0);
        last_q = 16'hFFFF;
        last_r = 16'd0;
        last_z = 1'b0;

        // Asynchronous reset in the middle of RUN.
        @(negedge clock);
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd3;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (8) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_quotient", {16'd0, quotient}, 32'd0);
        chk("async_rst_remainder", {16'd0, remainder}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        chk("no_done_after_abort", done_cnt, 0);
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        do_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17);

        // Random operands against a behavioural a/b, a%b reference.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ra, rb, eq, er;
            int sel;
            ra  = 16'($urandom_range(0, 65535));
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 16'd0;
            else if (sel == 1) rb = 16'($urandom_range(1, 15));
            else if (sel == 2) rb = 16'($urandom_range(32768, 65535));
            else               rb = 16'($urandom_range(1, 65535));
            if (rb == 16'd0) begin
                eq = 16'hFFFF;
                er = ra;
            end else begin
                eq = ra / rb;
                er = ra % rb;
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            do_op(ra, rb, eq, er, (rb == 16'd0), (rb == 16'd0) ? 1 : 17);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
